song_sequencer: RTL and testbench

- Control FSM that sequences the song ROM for the note player.
- Selects the song; generates the ROM address {song, note_index}; fetches and latches each note/duration.
- Issues a one-cycle new_note per note, then waits for note_done from the note player.
- Handles pause, skip-to-next-song, loop mode and end-of-song detection. Sits between the user-control logic and the song ROM / note player.

---
 rtl/song_sequencer.sv | 112 +++++++++++
 tb/tb_song_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: walks the song ROM entry by entry, hands each note to the note player and handles pause, skip and loop
module song_sequencer #(
  parameter int SONG_W  = 2,
  parameter int NOTE_AW = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play,
  input  logic                      next_song,
  input  logic                      loop,
  input  logic                      note_done,
  input  logic [11:0]               rom_dout,
  output logic [SONG_W+NOTE_AW-1:0] rom_addr,
  output logic [5:0]                note,
  output logic [5:0]                duration,
  output logic                      new_note,
  output logic                      song_done,
  output logic                      busy,
  output logic [SONG_W-1:0]         cur_song
);
  localparam int CW = $clog2(ROM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(ROM_LAT - 1);
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, PLAY, WAIT, ADVANCE, END} state_t;
  state_t state;
  logic [SONG_W-1:0] song_idx;
  logic [NOTE_AW-1:0] note_idx;
  logic [CW-1:0] cnt;
  logic done_pend;
  assign rom_addr = {song_idx, note_idx};
  assign cur_song = song_idx;
  assign busy = (state != IDLE);
  // sequencing FSM; a skip request overrides whatever the current state would do
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      song_idx <= '0;
      note_idx <= '0;
      note <= '0;
      duration <= '0;
      new_note <= 1'b0;
      song_done <= 1'b0;
      done_pend <= 1'b0;
      cnt <= '0;
    end else begin
      new_note <= 1'b0;
      song_done <= 1'b0;
      if (next_song && state != IDLE) begin
        song_idx <= song_idx + 1'b1;
        note_idx <= '0;
        done_pend <= 1'b0;
        cnt <= '0;
        state <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            if (next_song) song_idx <= song_idx + 1'b1;
            if (play) begin
              note_idx <= '0;
              cnt <= '0;
              state <= FETCH;
            end
          end
          FETCH: begin
            if (play || cnt != '0) begin
              if (cnt == LAST) begin
                cnt <= '0;
                state <= CHECK;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          CHECK: begin
            if (rom_dout[5:0] == 6'd0) begin
              song_done <= 1'b1;
              state <= END;
            end else begin
              note <= rom_dout[11:6];
              duration <= rom_dout[5:0];
              new_note <= 1'b1;
              state <= PLAY;
            end
          end
          PLAY: state <= WAIT;
          WAIT: begin
            if (done_pend && play) begin
              done_pend <= 1'b0;
              state <= ADVANCE;
            end else if (note_done) begin
              done_pend <= 1'b1;
            end
          end
          ADVANCE: begin
            if (&note_idx) begin
              song_done <= 1'b1;
              state <= END;
            end else begin
              note_idx <= note_idx + 1'b1;
              state <= FETCH;
            end
          end
          END: begin
            note_idx <= '0;
            state <= loop ? FETCH : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: table-driven, directed and randomized checks of song_sequencer against a ROM walk model
module tb_song_sequencer;
  logic clk = 0, reset = 0, play = 0, next_song = 0, loop = 0, note_done = 0;
  logic [11:0] rom_dout = '0;
  logic [6:0] rom_addr;
  logic [5:0] note, duration;
  logic new_note, song_done, busy;
  logic [1:0] cur_song;
  logic [11:0] mem [128];
  int checks = 0, errors = 0;

  typedef struct {
    logic p, n, d, b, nn, sd;
    int a, nt, du;
  } vec_t;
  vec_t tbl [26];

  song_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .next_song(next_song), .loop(loop),
    .note_done(note_done), .rom_dout(rom_dout), .rom_addr(rom_addr), .note(note),
    .duration(duration), .new_note(new_note), .song_done(song_done), .busy(busy),
    .cur_song(cur_song)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= mem[rom_addr];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask

  function automatic vec_t v(input logic p, n, d, b, nn, sd, input int a, nt, du);
    vec_t r;
    r.p = p; r.n = n; r.d = d; r.b = b; r.nn = nn; r.sd = sd; r.a = a; r.nt = nt; r.du = du;
    return r;
  endfunction

  task automatic wait_evt(output int k, output int c);
    k = 0;
    c = 0;
    while (k == 0 && c < 100) begin
      @(negedge clk);
      c++;
      if (new_note) k = 1;
      else if (song_done) k = 2;
    end
    if (k == 0) begin
      checks++;
      errors++;
      $display("FAIL evt_timeout actual=none expected=event within 100 cycles");
    end
  endtask

  task automatic pulse_next;
    next_song = 1;
    @(negedge clk);
    next_song = 0;
  endtask

  task automatic run_song(input int song, input int exp_n);
    int n = 0, k, c;
    bit done = 0;
    while (!done) begin
      wait_evt(k, c);
      if (k == 1) begin
        chk("song_addr", rom_addr, song * 32 + n);
        chk("song_data", {note, duration}, mem[song * 32 + n]);
        n++;
        @(negedge clk);
        note_done = 1;
        @(negedge clk);
        note_done = 0;
      end else begin
        done = 1;
        chk("song_count", n, exp_n);
      end
    end
  endtask

  initial begin
    int k, c, msong, midx, mend, ek, r;
    bit seen;
    for (int i = 0; i < 128; i++) mem[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
    mem[0] = {6'd10, 6'd3}; mem[1] = {6'd20, 6'd4}; mem[2] = {6'd30, 6'd5}; mem[3] = 12'd0;
    for (int i = 0; i < 32; i++) mem[32 + i] = {6'(i + 1), 6'(i + 2)};
    mem[64] = {6'd40, 6'd7}; mem[65] = {6'd41, 6'd8}; mem[66] = 12'd0;
    mem[96] = {6'd50, 6'd9};
    tbl[0]  = v(0,1,0, 0,0,0, 32, 0, 0);
    tbl[1]  = v(0,1,0, 0,0,0, 64, 0, 0);
    tbl[2]  = v(0,1,0, 0,0,0, 96, 0, 0);
    tbl[3]  = v(0,1,0, 0,0,0, 0, 0, 0);
    tbl[4]  = v(1,0,0, 1,0,0, 0, 0, 0);
    tbl[5]  = v(1,0,0, 1,0,0, 0, 0, 0);
    tbl[6]  = v(1,0,0, 1,1,0, 0, 10, 3);
    tbl[7]  = v(1,0,0, 1,0,0, 0, 10, 3);
    tbl[8]  = v(1,0,1, 1,0,0, 0, 10, 3);
    tbl[9]  = v(1,0,0, 1,0,0, 0, 10, 3);
    tbl[10] = v(1,0,0, 1,0,0, 1, 10, 3);
    tbl[11] = v(1,0,0, 1,0,0, 1, 10, 3);
    tbl[12] = v(1,0,0, 1,1,0, 1, 20, 4);
    tbl[13] = v(1,0,0, 1,0,0, 1, 20, 4);
    tbl[14] = v(1,0,1, 1,0,0, 1, 20, 4);
    tbl[15] = v(1,0,0, 1,0,0, 1, 20, 4);
    tbl[16] = v(1,0,0, 1,0,0, 2, 20, 4);
    tbl[17] = v(1,0,0, 1,0,0, 2, 20, 4);
    tbl[18] = v(1,0,0, 1,1,0, 2, 30, 5);
    tbl[19] = v(1,0,0, 1,0,0, 2, 30, 5);
    tbl[20] = v(1,0,1, 1,0,0, 2, 30, 5);
    tbl[21] = v(1,0,0, 1,0,0, 2, 30, 5);
    tbl[22] = v(1,0,0, 1,0,0, 3, 30, 5);
    tbl[23] = v(1,0,0, 1,0,0, 3, 30, 5);
    tbl[24] = v(0,0,0, 1,0,1, 3, 30, 5);
    tbl[25] = v(0,0,0, 0,0,0, 0, 30, 5);
    repeat (3) @(negedge clk);
    chk("reset_state", {busy, new_note, song_done, rom_addr, note, duration, cur_song}, 0);
    reset = 1;
    for (int i = 0; i < 26; i++) begin
      play = tbl[i].p; next_song = tbl[i].n; note_done = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {busy, new_note, song_done, rom_addr, note, duration},
          {tbl[i].b, tbl[i].nn, tbl[i].sd, 7'(tbl[i].a), 6'(tbl[i].nt), 6'(tbl[i].du)});
    end
    next_song = 0; note_done = 0;
    // reset asserted mid-WAIT on song 2
    pulse_next; pulse_next;
    play = 1;
    wait_evt(k, c);
    chk("pre_reset_addr", rom_addr, 64);
    @(negedge clk);
    reset = 0; play = 0;
    repeat (2) @(negedge clk);
    chk("reset_mid_wait", {busy, new_note, song_done, rom_addr, note, duration, cur_song}, 0);
    reset = 1;
    @(negedge clk);
    chk("after_reset_idle", {busy, rom_addr}, 0);
    // full 32-entry song without terminator
    pulse_next;
    play = 1;
    run_song(1, 32);
    play = 0;
    @(negedge clk);
    chk("full_song_end", {busy, rom_addr}, {1'b0, 7'd32});
    // loop mode on the 2-note song
    pulse_next;
    loop = 1; play = 1;
    run_song(2, 2);
    @(negedge clk);
    chk("loop_busy", {busy, rom_addr}, {1'b1, 7'd64});
    wait_evt(k, c);
    chk("loop_restart", {4'(k), rom_addr}, {4'd1, 7'd64});
    loop = 0;
    // pause with note_done landing on the same cycle play falls
    @(negedge clk);
    play = 0; note_done = 1;
    @(negedge clk);
    note_done = 0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (new_note) seen = 1;
    end
    chk("pause_hold", {seen, busy, rom_addr}, {1'b0, 1'b1, 7'd64});
    play = 1;
    wait_evt(k, c);
    chk("pause_resume", {4'(k), 8'(c), rom_addr}, {4'd1, 8'd4, 7'd65});
    @(negedge clk);
    note_done = 1;
    @(negedge clk);
    note_done = 0;
    wait_evt(k, c);
    chk("pause_song_end", k, 2);
    play = 0;
    // skip from song 3 coincident with note_done
    @(negedge clk);
    pulse_next;
    play = 1;
    wait_evt(k, c);
    chk("song3_first", {cur_song, rom_addr}, {2'd3, 7'd96});
    @(negedge clk);
    next_song = 1; note_done = 1;
    @(negedge clk);
    next_song = 0; note_done = 0;
    wait_evt(k, c);
    chk("skip_wrap", {4'(k), cur_song, rom_addr}, {4'd1, 2'd0, 7'd0});
    // randomized run against a ROM-walk model
    for (int i = 0; i < 128; i++)
      mem[i] = {6'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63))};
    for (int s = 0; s < 4; s++) if (mem[s * 32][5:0] == 6'd0) mem[s * 32][5:0] = 6'd1;
    play = 0; reset = 0;
    repeat (2) @(negedge clk);
    reset = 1; loop = 1; play = 1;
    msong = 0; midx = 0; mend = 0;
    for (int it = 0; it < 80; it++) begin
      ek = (mend != 0 || mem[msong * 32 + midx][5:0] == 6'd0) ? 2 : 1;
      wait_evt(k, c);
      chk("rnd_kind", k, ek);
      if (k != ek) break;
      if (k == 2) begin
        midx = 0; mend = 0;
        continue;
      end
      chk("rnd_note", {rom_addr, note, duration}, {7'(msong * 32 + midx), mem[msong * 32 + midx]});
      repeat ($urandom_range(1, 4)) @(negedge clk);
      r = $urandom_range(0, 5);
      if (r == 0) begin
        next_song = 1; note_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        next_song = 0; note_done = 0;
        msong = (msong + 1) % 4; midx = 0; mend = 0;
      end else begin
        if (r == 1) play = 0;
        note_done = 1;
        @(negedge clk);
        note_done = 0;
        if (r == 1) begin
          repeat ($urandom_range(1, 6)) @(negedge clk);
          play = 1;
        end
        if (midx == 31) mend = 1;
        else midx++;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
